// File: rtl/i2c_bus_arbiter.sv
// ---------------------------------------------------------------------------
// i2c_bus_arbiter
//
// Shares one I2C master core between three requesters. A round-robin
// arbiter picks a winner, latches its command (address, direction, write
// byte) onto the master command bus, strobes m_start once the master is
// idle, waits for the master to finish, then returns the result with a
// one-cycle done pulse to the winner.
//
// Optional feature (macro I2C_ARB_TIMEOUT_EN): a watchdog bounds the time
// spent waiting for m_done. When it expires the transaction is released
// with nack=1 and timeout=1. Without the macro the watchdog does not exist
// and timeout is tied low.
//
// Parameters
//   TIMEOUT_CYCLES  WAIT-state cycle limit used by the watchdog
//
// Ports
//   clk, reset        system clock, synchronous active-high reset
//   req[2:0]          per-requester request, held until its done pulse
//   req_addr[20:0]    7-bit slave address per requester (i -> [7i+6:7i])
//   req_rw[2:0]       per-requester direction, 1=read 0=write
//   req_wdata[23:0]   write byte per requester (i -> [8i+7:8i])
//   gnt[2:0]          one-hot grant for the owned transaction
//   done[2:0]         one-cycle completion pulse to the winner
//   rdata[7:0], nack  result of the last transaction
//   timeout           last transaction ended by watchdog
//   m_start           one-cycle start strobe to the master core
//   m_addr, m_rw, m_wdata   latched command to the master core
//   m_busy, m_done, m_nack, m_rdata   master core status and result
// ---------------------------------------------------------------------------
module i2c_bus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  req,
    input  logic [20:0] req_addr,
    input  logic [2:0]  req_rw,
    input  logic [23:0] req_wdata,
    output logic [2:0]  gnt,
    output logic [2:0]  done,
    output logic [7:0]  rdata,
    output logic        nack,
    output logic        timeout,
    output logic        m_start,
    output logic [6:0]  m_addr,
    output logic        m_rw,
    output logic [7:0]  m_wdata,
    input  logic        m_busy,
    input  logic        m_done,
    input  logic        m_nack,
    input  logic [7:0]  m_rdata
);

    // state   | meaning
    // IDLE    | no owner; arbitrate among pending requests
    // ISSUE   | owner granted; strobe m_start once the master is idle
    // WAIT    | master running; wait for m_done (or watchdog expiry)
    // RELEASE | done pulse to owner; drop grant, advance pointer
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    state_t      state_q;
    logic [2:0]  gnt_q;
    logic [2:0]  done_q;
    logic [1:0]  ptr_q;
    logic [1:0]  win_q;
    logic        m_start_q;
    logic [6:0]  m_addr_q;
    logic        m_rw_q;
    logic [7:0]  m_wdata_q;
    logic [7:0]  rdata_q;
    logic        nack_q;

    logic [1:0]  cand1_d;
    logic [1:0]  cand2_d;
    logic [1:0]  win_d;
    logic [6:0]  sel_addr_d;
    logic        sel_rw_d;
    logic [7:0]  sel_wdata_d;

    function automatic logic [1:0] inc3(input logic [1:0] v);
        return (v == 2'd2) ? 2'd0 : v + 2'd1;
    endfunction

`ifdef I2C_ARB_TIMEOUT_EN
    localparam int unsigned WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [WD_W-1:0] wd_q;
    logic            timeout_q;
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    // Round-robin winner: first pending requester at ptr, ptr+1, ptr+2 (mod 3).
    always_comb begin
        cand1_d = inc3(ptr_q);
        cand2_d = inc3(cand1_d);
        if (req[ptr_q]) begin
            win_d = ptr_q;
        end else if (req[cand1_d]) begin
            win_d = cand1_d;
        end else begin
            win_d = cand2_d;
        end
        case (win_d)
            2'd1: begin
                sel_addr_d  = req_addr[13:7];
                sel_rw_d    = req_rw[1];
                sel_wdata_d = req_wdata[15:8];
            end
            2'd2: begin
                sel_addr_d  = req_addr[20:14];
                sel_rw_d    = req_rw[2];
                sel_wdata_d = req_wdata[23:16];
            end
            default: begin
                sel_addr_d  = req_addr[6:0];
                sel_rw_d    = req_rw[0];
                sel_wdata_d = req_wdata[7:0];
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            gnt_q     <= 3'b000;
            done_q    <= 3'b000;
            ptr_q     <= 2'd0;
            win_q     <= 2'd0;
            m_start_q <= 1'b0;
            m_addr_q  <= 7'd0;
            m_rw_q    <= 1'b0;
            m_wdata_q <= 8'd0;
            rdata_q   <= 8'd0;
            nack_q    <= 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
            wd_q      <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (|req) begin
                        gnt_q     <= 3'b001 << win_d;
                        win_q     <= win_d;
                        m_addr_q  <= sel_addr_d;
                        m_rw_q    <= sel_rw_d;
                        m_wdata_q <= sel_wdata_d;
                        // Strobe in the grant cycle already if the master is idle.
                        m_start_q <= ~m_busy;
                        state_q   <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (m_start_q) begin
                        m_start_q <= 1'b0;
                        state_q   <= ST_WAIT;
`ifdef I2C_ARB_TIMEOUT_EN
                        wd_q      <= WD_W'(TIMEOUT_CYCLES - 1);
`endif
                    end else if (!m_busy) begin
                        m_start_q <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (m_done) begin
                        rdata_q   <= m_rdata;
                        nack_q    <= m_nack;
                        done_q    <= gnt_q;
                        state_q   <= ST_RELEASE;
`ifdef I2C_ARB_TIMEOUT_EN
                        timeout_q <= 1'b0;
`endif
                    end
`ifdef I2C_ARB_TIMEOUT_EN
                    // Terminal count reached: release with error, rdata untouched.
                    else if (wd_q == '0) begin
                        nack_q    <= 1'b1;
                        timeout_q <= 1'b1;
                        done_q    <= gnt_q;
                        state_q   <= ST_RELEASE;
                    end else begin
                        wd_q <= wd_q - 1'b1;
                    end
`endif
                end
                ST_RELEASE: begin
                    done_q  <= 3'b000;
                    gnt_q   <= 3'b000;
                    ptr_q   <= inc3(win_q);
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt     = gnt_q;
    assign done    = done_q;
    assign rdata   = rdata_q;
    assign nack    = nack_q;
    assign m_start = m_start_q;
    assign m_addr  = m_addr_q;
    assign m_rw    = m_rw_q;
    assign m_wdata = m_wdata_q;

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
module tb_i2c_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  req;
    logic [20:0] req_addr;
    logic [2:0]  req_rw;
    logic [23:0] req_wdata;
    logic [2:0]  gnt;
    logic [2:0]  done;
    logic [7:0]  rdata;
    logic        nack;
    logic        timeout;
    logic        m_start;
    logic [6:0]  m_addr;
    logic        m_rw;
    logic [7:0]  m_wdata;
    logic        m_busy;
    logic        m_done;
    logic        m_nack;
    logic [7:0]  m_rdata;

    int n_cmp = 0;
    int n_err = 0;

    i2c_bus_arbiter #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset(reset), .req(req), .req_addr(req_addr), .req_rw(req_rw),
        .req_wdata(req_wdata), .gnt(gnt), .done(done), .rdata(rdata), .nack(nack),
        .timeout(timeout), .m_start(m_start), .m_addr(m_addr), .m_rw(m_rw),
        .m_wdata(m_wdata), .m_busy(m_busy), .m_done(m_done), .m_nack(m_nack),
        .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    // Waits (bounded) for a start strobe; inputs change and outputs are sampled at negedges.
    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (m_start === 1'b1) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    // Master core model: finishes the running transaction after dly cycles.
    // On return the done pulse (if any) is visible.
    task automatic respond(input logic [7:0] rd, input logic nk, input int dly);
        repeat (dly + 1) @(negedge clk);
        m_done  = 1'b1;
        m_rdata = rd;
        m_nack  = nk;
        @(negedge clk);
        m_done  = 1'b0;
        m_nack  = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; req = 3'b000; req_addr = '0; req_rw = '0; req_wdata = '0;
        m_busy = 1'b0; m_done = 1'b0; m_nack = 1'b0; m_rdata = 8'h00;
        repeat (3) @(negedge clk);
        n_cmp++; if (gnt !== 3'b000) begin n_err++; $display("FAIL reset_gnt: got %b want 000", gnt); end
        n_cmp++; if (done !== 3'b000) begin n_err++; $display("FAIL reset_done: got %b want 000", done); end
        n_cmp++; if (m_start !== 1'b0) begin n_err++; $display("FAIL reset_m_start: got %b want 0", m_start); end
        n_cmp++; if ({m_addr, m_rw, m_wdata} !== 16'h0) begin n_err++; $display("FAIL reset_cmd: got %h want 0000", {m_addr, m_rw, m_wdata}); end
        n_cmp++; if ({rdata, nack, timeout} !== 10'h0) begin n_err++; $display("FAIL reset_result: got %h want 000", {rdata, nack, timeout}); end
        reset = 1'b0;
        @(negedge clk);
        n_cmp++; if (gnt !== 3'b000) begin n_err++; $display("FAIL idle_no_req_gnt: got %b want 000", gnt); end
    endtask

    task automatic test_read;
        req_addr = 21'h48; req_rw = 3'b001; req_wdata = '0; m_busy = 1'b0;
        req = 3'b001;
        @(negedge clk);
        n_cmp++; if (gnt !== 3'b001) begin n_err++; $display("FAIL read_gnt: got %b want 001", gnt); end
        n_cmp++; if (m_start !== 1'b1) begin n_err++; $display("FAIL read_start_latency: got %b want 1", m_start); end
        n_cmp++; if (m_addr !== 7'h48) begin n_err++; $display("FAIL read_m_addr: got %h want 48", m_addr); end
        n_cmp++; if (m_rw !== 1'b1) begin n_err++; $display("FAIL read_m_rw: got %b want 1", m_rw); end
        @(negedge clk);
        n_cmp++; if (m_start !== 1'b0) begin n_err++; $display("FAIL read_start_once: got %b want 0", m_start); end
        respond(8'hA5, 1'b0, 2);
        n_cmp++; if (done !== 3'b001) begin n_err++; $display("FAIL read_done: got %b want 001", done); end
        n_cmp++; if (rdata !== 8'hA5) begin n_err++; $display("FAIL read_rdata: got %h want a5", rdata); end
        n_cmp++; if (nack !== 1'b0) begin n_err++; $display("FAIL read_nack: got %b want 0", nack); end
        req = 3'b000;
        @(negedge clk);
        n_cmp++; if ({gnt, done} !== 6'b0) begin n_err++; $display("FAIL read_release: got gnt %b done %b want 000/000", gnt, done); end
        @(negedge clk);
    endtask

    task automatic test_write_nack;
        req_addr = 21'h51 << 14; req_rw = 3'b000; req_wdata = 24'h3C << 16;
        req = 3'b100;
        @(negedge clk);
        n_cmp++; if (gnt !== 3'b100) begin n_err++; $display("FAIL wr_gnt: got %b want 100", gnt); end
        n_cmp++; if (m_wdata !== 8'h3C) begin n_err++; $display("FAIL wr_m_wdata: got %h want 3c", m_wdata); end
        n_cmp++; if ({m_addr, m_rw} !== {7'h51, 1'b0}) begin n_err++; $display("FAIL wr_cmd: got %h/%b want 51/0", m_addr, m_rw); end
        respond(8'h00, 1'b1, 1);
        n_cmp++; if (done !== 3'b100) begin n_err++; $display("FAIL wr_done: got %b want 100", done); end
        n_cmp++; if (nack !== 1'b1) begin n_err++; $display("FAIL wr_nack: got %b want 1", nack); end
        n_cmp++; if (timeout !== 1'b0) begin n_err++; $display("FAIL wr_timeout: got %b want 0", timeout); end
        req = 3'b000;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_busy_delay;
        bit bad_start = 1'b0, bad_done = 1'b0, addr_moved = 1'b0;
        int starts = 0;
        m_busy = 1'b1;
        req_addr = 21'h2A << 7; req_rw = 3'b010; req_wdata = 24'h00A100;
        req = 3'b010;
        @(negedge clk);
        n_cmp++; if ({gnt, m_start} !== 4'b0100) begin n_err++; $display("FAIL busy_grant: got gnt %b start %b want 010/0", gnt, m_start); end
        for (int i = 0; i < 9; i++) begin
            m_done = (i == 3);   // stray m_done outside WAIT must be ignored
            @(negedge clk);
            if (m_start !== 1'b0) bad_start = 1'b1;
            if (done !== 3'b000) bad_done = 1'b1;
            if (m_addr !== 7'h2A) addr_moved = 1'b1;
        end
        m_done = 1'b0;
        m_busy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (m_start === 1'b1) starts++;
            if (m_addr !== 7'h2A) addr_moved = 1'b1;
        end
        n_cmp++; if (bad_start) begin n_err++; $display("FAIL busy_start_while_busy: got start during busy want none"); end
        n_cmp++; if (bad_done) begin n_err++; $display("FAIL busy_stray_m_done: got done pulse want none"); end
        n_cmp++; if (starts != 1) begin n_err++; $display("FAIL busy_start_count: got %0d want 1", starts); end
        n_cmp++; if (addr_moved) begin n_err++; $display("FAIL busy_m_addr_stable: got change want %h held", 7'h2A); end
        respond(8'h5A, 1'b0, 0);
        n_cmp++; if ({done, rdata} !== {3'b010, 8'h5A}) begin n_err++; $display("FAIL busy_done: got %b/%h want 010/5a", done, rdata); end
        req = 3'b000;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_timeout;
        bit ok;
        req_addr = 21'h10; req_rw = 3'b001; req = 3'b001; m_busy = 1'b0;
        wait_start(ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL to_start: got no m_start want one"); end
`ifdef I2C_ARB_TIMEOUT_EN
        begin
            int cnt = 0;
            for (int i = 1; i <= 40; i++) begin
                @(negedge clk);
                if (done !== 3'b000) begin cnt = i; break; end
            end
            // 16 cycles in WAIT, then the release cycle after the strobe cycle
            n_cmp++; if (cnt != 17) begin n_err++; $display("FAIL to_latency: got %0d want 17", cnt); end
            n_cmp++; if (done !== 3'b001) begin n_err++; $display("FAIL to_done: got %b want 001", done); end
            n_cmp++; if ({nack, timeout} !== 2'b11) begin n_err++; $display("FAIL to_flags: got %b want 11", {nack, timeout}); end
            n_cmp++; if (rdata !== 8'h5A) begin n_err++; $display("FAIL to_rdata_kept: got %h want 5a", rdata); end
        end
`else
        begin
            bit held = 1'b1;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (gnt !== 3'b001 || done !== 3'b000) held = 1'b0;
            end
            n_cmp++; if (!held) begin n_err++; $display("FAIL to_held: got release want gnt 001 held"); end
            respond(8'h77, 1'b0, 0);
            n_cmp++; if ({done, timeout} !== 4'b0010) begin n_err++; $display("FAIL to_late_done: got %b/%b want 001/0", done, timeout); end
        end
`endif
        req = 3'b000;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid;
        bit ok;
        bit seen_done = 1'b0;
        req_addr = {7'h33, 7'h22, 7'h11}; req_rw = 3'b000;
        req = 3'b001;
        wait_start(ok);
        respond(8'h01, 1'b0, 0);
        req = 3'b000;
        repeat (2) @(negedge clk);
        req = 3'b010;
        wait_start(ok);
        n_cmp++; if (!ok || gnt !== 3'b010) begin n_err++; $display("FAIL rstmid_pre_gnt: got %b want 010", gnt); end
        @(negedge clk);
        reset = 1'b1;
        req = 3'b000;
        @(negedge clk);
        n_cmp++; if ({gnt, done, m_start} !== 7'b0) begin n_err++; $display("FAIL rstmid_drop: got gnt %b done %b want 000/000", gnt, done); end
        reset = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (done !== 3'b000) seen_done = 1'b1;
        end
        n_cmp++; if (seen_done) begin n_err++; $display("FAIL rstmid_no_done: got done pulse want none"); end
        req = 3'b111;
        @(negedge clk);
        n_cmp++; if (gnt !== 3'b001) begin n_err++; $display("FAIL rstmid_ptr0: got %b want 001", gnt); end
        respond(8'h02, 1'b0, 0);
        req = 3'b000;
        repeat (2) @(negedge clk);
    endtask

    // Random requests against a round-robin reference: winner is the first
    // pending requester counted upward from the pointer, pointer = winner+1.
    task automatic test_random;
        logic [2:0] pend = 3'b000;
        logic [6:0] a [3];
        logic [2:0] rwv = 3'b000;
        logic [7:0] w [3];
        int ptr_m = 0;
        int waited [3];
        int win, j, maxw;
        logic [7:0] rd;
        logic nk;
        logic [2:0] exp_g;
        for (int i = 0; i < 3; i++) begin a[i] = 7'h0; w[i] = 8'h0; waited[i] = 0; end
        reset = 1'b1; req = 3'b000;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1) begin
                    pend[i] = 1'b1;
                    a[i] = 7'($urandom);
                    rwv[i] = 1'($urandom);
                    w[i] = 8'($urandom);
                    waited[i] = 0;
                end
            end
            if (pend == 3'b000) begin
                pend[0] = 1'b1; a[0] = 7'($urandom); rwv[0] = 1'($urandom); w[0] = 8'($urandom); waited[0] = 0;
            end
            req_addr = {a[2], a[1], a[0]};
            req_rw = rwv;
            req_wdata = {w[2], w[1], w[0]};
            req = pend;
            win = -1;
            for (int k = 0; k < 3; k++) begin
                j = (ptr_m + k) % 3;
                if (win < 0 && pend[j]) win = j;
            end
            exp_g = 3'b001 << win;
            @(negedge clk);
            n_cmp++; if (gnt !== exp_g) begin n_err++; $display("FAIL rnd_gnt[%0d]: got %b want %b", t, gnt, exp_g); end
            n_cmp++; if ({m_start, m_addr, m_rw, m_wdata} !== {1'b1, a[win], rwv[win], w[win]}) begin
                n_err++; $display("FAIL rnd_cmd[%0d]: got %b/%h/%b/%h want 1/%h/%b/%h", t, m_start, m_addr, m_rw, m_wdata, a[win], rwv[win], w[win]);
            end
            maxw = 0;
            for (int i = 0; i < 3; i++) begin
                if (gnt[i]) waited[i] = 0;
                else if (pend[i]) waited[i]++;
                if (waited[i] > maxw) maxw = waited[i];
            end
            n_cmp++; if (maxw > 2) begin n_err++; $display("FAIL rnd_starve[%0d]: got wait %0d want <=2", t, maxw); end
            rd = 8'($urandom);
            nk = 1'($urandom);
            respond(rd, nk, $urandom_range(0, 3));
            n_cmp++; if ({done, rdata, nack, timeout} !== {exp_g, rd, nk, 1'b0}) begin
                n_err++; $display("FAIL rnd_done[%0d]: got %b/%h/%b/%b want %b/%h/%b/0", t, done, rdata, nack, timeout, exp_g, rd, nk);
            end
            pend[win] = 1'b0;
            req = pend;
            ptr_m = (win + 1) % 3;
        end
        req = 3'b000;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_rr_order;
        bit ok;
        int ptr_m = 0;
        logic [2:0] exp_g;
        reset = 1'b1;
        req_addr = {7'h03, 7'h02, 7'h01}; req_rw = 3'b111; req_wdata = '0;
        req = 3'b111;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            exp_g = 3'b001 << ptr_m;
            wait_start(ok);
            n_cmp++; if (!ok || gnt !== exp_g) begin n_err++; $display("FAIL rr_gnt[%0d]: got %b want %b", k, gnt, exp_g); end
            respond(8'(k), 1'b0, 0);
            n_cmp++; if (done !== exp_g) begin n_err++; $display("FAIL rr_done[%0d]: got %b want %b", k, done, exp_g); end
            ptr_m = (ptr_m + 1) % 3;
        end
        req = 3'b000;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_read();
        test_write_nack();
        test_busy_delay();
        test_timeout();
        test_reset_mid();
        test_random();
        test_rr_order();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
